// File: rtl/data_sync_hs.sv
// Receive side of a four-phase REQ/ACK bus crossing: captures the source bus on a synchronized
// request and hands it to a VALID/READY consumer. Define DATA_SYNC_HS_ERR_EN to add the sticky ERR output.

// state | meaning
// IDLE  | no transfer; waiting for sync_req high
// HOLD  | word captured, out_valid high, waiting for out_ready
// ACKED | word accepted, ack high, waiting for sync_req low
module data_sync_hs #(
    parameter int BUS_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sync_req,
    input  logic [BUS_WIDTH-1:0] unsync_bus,
    input  logic                 out_ready,
    output logic [BUS_WIDTH-1:0] sync_bus,
    output logic                 out_valid,
    output logic                 ack
`ifdef DATA_SYNC_HS_ERR_EN
    ,
    output logic                 err
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        ACKED = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [BUS_WIDTH-1:0] bus_nxt;
    logic                 valid_nxt;
    logic                 ack_nxt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            sync_bus  <= '0;
            out_valid <= 1'b0;
            ack       <= 1'b0;
        end else begin
            state     <= state_nxt;
            sync_bus  <= bus_nxt;
            out_valid <= valid_nxt;
            ack       <= ack_nxt;
        end
    end

    // The bus is only loaded on IDLE->HOLD, so any later change on unsync_bus is ignored.
    always_comb begin
        state_nxt = state;
        bus_nxt   = sync_bus;
        valid_nxt = out_valid;
        ack_nxt   = ack;
        case (state)
            IDLE: begin
                valid_nxt = 1'b0;
                ack_nxt   = 1'b0;
                if (sync_req) begin
                    bus_nxt   = unsync_bus;
                    valid_nxt = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                valid_nxt = 1'b1;
                ack_nxt   = 1'b0;
                if (out_ready) begin
                    valid_nxt = 1'b0;
                    ack_nxt   = 1'b1;
                    state_nxt = ACKED;
                end
            end
            ACKED: begin
                valid_nxt = 1'b0;
                ack_nxt   = 1'b1;
                if (!sync_req) begin
                    ack_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                valid_nxt = 1'b0;
                ack_nxt   = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef DATA_SYNC_HS_ERR_EN
    logic err_nxt;

    // Request withdrawn before ack: flag it, but still deliver the held word.
    always_comb begin
        err_nxt = err;
        if (state == HOLD && !sync_req) begin
            err_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            err <= 1'b0;
        end else begin
            err <= err_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_data_sync_hs.sv
// Directed self-checking bench for data_sync_hs; inputs change 1 time unit after each rising edge
// and outputs are compared at that same point, away from the edge.
`timescale 1ns/1ps
module tb_data_sync_hs;

    logic       clk;
    logic       rst;
    logic       sync_req;
    logic [7:0] unsync_bus;
    logic       out_ready;
    logic [7:0] sync_bus;
    logic       out_valid;
    logic       ack;
`ifdef DATA_SYNC_HS_ERR_EN
    logic       err;
`endif

    int checks = 0;
    int errors = 0;

    data_sync_hs #(.BUS_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .sync_req   (sync_req),
        .unsync_bus (unsync_bus),
        .out_ready  (out_ready),
        .sync_bus   (sync_bus),
        .out_valid  (out_valid),
        .ack        (ack)
`ifdef DATA_SYNC_HS_ERR_EN
        ,
        .err        (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] e_bus, input logic e_valid, input logic e_ack);
        chk({tag, ".sync_bus"}, {24'd0, sync_bus}, {24'd0, e_bus});
        chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, e_valid});
        chk({tag, ".ack"}, {31'd0, ack}, {31'd0, e_ack});
    endtask

    logic [7:0] accepted[$];
    int         cyc;
    logic       timed_out;

    initial begin
        rst        = 1'b0;
        sync_req   = 1'b0;
        unsync_bus = 8'h00;
        out_ready  = 1'b0;

        // Reset and idle
        tick();
        tick();
        chk_out("reset", 8'h00, 1'b0, 1'b0);
`ifdef DATA_SYNC_HS_ERR_EN
        chk("reset.err", {31'd0, err}, 32'd0);
`endif
        rst        = 1'b1;
        unsync_bus = 8'hA5;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out("idle", 8'h00, 1'b0, 1'b0);
        end

        // Basic transfer with out_ready held high
        unsync_bus = 8'h3C;
        out_ready  = 1'b1;
        sync_req   = 1'b1;
        tick();
        chk_out("basic.capture", 8'h3C, 1'b1, 1'b0);
        tick();
        chk_out("basic.ack", 8'h3C, 1'b0, 1'b1);
        tick();
        chk_out("basic.ack_hold", 8'h3C, 1'b0, 1'b1);
        sync_req = 1'b0;
        tick();
        chk_out("basic.release", 8'h3C, 1'b0, 1'b0);
        tick();
        chk_out("basic.idle", 8'h3C, 1'b0, 1'b0);

        // Backpressure with bus changing during the stall
        out_ready  = 1'b0;
        unsync_bus = 8'h55;
        sync_req   = 1'b1;
        tick();
        chk_out("bp.capture", 8'h55, 1'b1, 1'b0);
        unsync_bus = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_out("bp.stall", 8'h55, 1'b1, 1'b0);
        end
        out_ready = 1'b1;
        tick();
        chk_out("bp.accept", 8'h55, 1'b0, 1'b1);
        sync_req = 1'b0;
        tick();
        chk_out("bp.release", 8'h55, 1'b0, 1'b0);
`ifdef DATA_SYNC_HS_ERR_EN
        chk("bp.err", {31'd0, err}, 32'd0);
`endif

        // Back-to-back four-phase transfers with random out_ready
        accepted.delete();
        for (int w = 1; w <= 4; w++) begin
            unsync_bus = 8'(w);
            sync_req   = 1'b1;
            timed_out  = 1'b1;
            for (cyc = 0; cyc < 50; cyc++) begin
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid && out_ready) accepted.push_back(sync_bus);
                tick();
                if (ack) begin
                    timed_out = 1'b0;
                    break;
                end
            end
            chk("b2b.ack_timeout", {31'd0, timed_out}, 32'd0);
            sync_req  = 1'b0;
            timed_out = 1'b1;
            for (cyc = 0; cyc < 50; cyc++) begin
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid && out_ready) accepted.push_back(sync_bus);
                tick();
                if (!ack) begin
                    timed_out = 1'b0;
                    break;
                end
            end
            chk("b2b.release_timeout", {31'd0, timed_out}, 32'd0);
            out_ready = 1'b0;
            tick();
        end
        chk("b2b.count", accepted.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < accepted.size()) chk("b2b.word", {24'd0, accepted[i]}, i + 1);
            else                     chk("b2b.word_missing", 32'd0, i + 1);
        end

        // Reset mid-transfer
        out_ready  = 1'b0;
        unsync_bus = 8'h77;
        sync_req   = 1'b1;
        tick();
        chk_out("rst.hold", 8'h77, 1'b1, 1'b0);
        rst = 1'b0;
        tick();
        chk_out("rst.in_hold", 8'h00, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        chk_out("rst.recapture", 8'h77, 1'b1, 1'b0);
        out_ready = 1'b1;
        tick();
        chk_out("rst.acked", 8'h77, 1'b0, 1'b1);
        rst = 1'b0;
        tick();
        chk_out("rst.in_acked", 8'h00, 1'b0, 1'b0);
        sync_req = 1'b0;
        rst      = 1'b1;
        tick();
        chk_out("rst.idle", 8'h00, 1'b0, 1'b0);

        // Request withdrawn while in HOLD: word still delivered
        out_ready  = 1'b0;
        unsync_bus = 8'hC3;
        sync_req   = 1'b1;
        tick();
        chk_out("early.capture", 8'hC3, 1'b1, 1'b0);
`ifdef DATA_SYNC_HS_ERR_EN
        chk("early.err0", {31'd0, err}, 32'd0);
`endif
        sync_req = 1'b0;
        tick();
        chk_out("early.hold", 8'hC3, 1'b1, 1'b0);
`ifdef DATA_SYNC_HS_ERR_EN
        chk("early.err_set", {31'd0, err}, 32'd1);
`endif
        tick();
        chk_out("early.hold2", 8'hC3, 1'b1, 1'b0);
        out_ready = 1'b1;
        tick();
        chk_out("early.accept", 8'hC3, 1'b0, 1'b1);
`ifdef DATA_SYNC_HS_ERR_EN
        chk("early.err_sticky", {31'd0, err}, 32'd1);
`endif
        tick();
        chk_out("early.exit", 8'hC3, 1'b0, 1'b0);
`ifdef DATA_SYNC_HS_ERR_EN
        chk("early.err_idle", {31'd0, err}, 32'd1);
`endif
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk_out("early.reset", 8'h00, 1'b0, 1'b0);
`ifdef DATA_SYNC_HS_ERR_EN
        chk("early.err_clear", {31'd0, err}, 32'd0);
`endif
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
